run_feeder: RTL and testbench

//  Upstream stage of the merger tree: turns an unsorted key stream into sorted ascending runs of up to RUN_LEN keys.

---
 rtl/bonsai_pkg.sv | 15 +
 rtl/run_sort_bank.sv | 100 ++++++++++
 rtl/run_feeder.sv | 117 +++++++++++
 tb/tb_run_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bonsai_pkg.sv
// Shared types and constants for the merger-tree front end.
package bonsai_pkg;

  localparam int unsigned KEY_W      = 32;
  // Key value reserved to mark the end of a sorted run.
  localparam int unsigned TERMINATOR = 0;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    SORTED,
    DRAINING
  } bank_state_t;

endpackage

// File: rtl/run_sort_bank.sv
// One insertion-sort register bank: keys are placed in order as they arrive, then the bank is
// read out ascending followed by a terminator word.
module run_sort_bank
  import bonsai_pkg::*;
#(
  parameter int unsigned W       = KEY_W,
  parameter int unsigned RUN_LEN = 8,
  parameter int unsigned CntW    = $clog2(RUN_LEN + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            insert_i,
  input  logic [W-1:0]    key_i,
  input  logic            close_i,
  input  logic            pop_i,
  output bank_state_t     state_o,
  output logic [CntW-1:0] count_o,
  output logic            at_term_o,
  output logic [W-1:0]    head_o
);

  bank_state_t        state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    idx_q, idx_d;
  logic [W-1:0]       entries_q [RUN_LEN];
  logic [W-1:0]       entries_d [RUN_LEN];
  logic [RUN_LEN-1:0] gt;
  logic               at_term;

  // Parallel compare: occupied slots whose key is strictly greater than the newcomer.
  always_comb begin
    for (int j = 0; j < RUN_LEN; j++) begin
      gt[j] = (CntW'(j) < count_q) && (entries_q[j] > key_i);
    end
  end

  // Read side: current drain word, or the terminator once every key has been popped.
  always_comb begin
    at_term = (idx_q == count_q);
    head_o  = '0;
    for (int j = 0; j < RUN_LEN; j++) begin
      if (!at_term && idx_q == CntW'(j)) head_o = entries_q[j];
    end
  end

  // Next state: insert with shift-up of larger keys, close, and pop/free.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    entries_d = entries_q;
    if (insert_i) begin
      // Ties do not shift, so equal keys keep arrival order.
      entries_d[0] = (gt[0] || count_q == '0) ? key_i : entries_q[0];
      for (int j = 1; j < RUN_LEN; j++) begin
        if (gt[j-1]) begin
          entries_d[j] = entries_q[j-1];
        end else if (gt[j] || count_q == CntW'(j)) begin
          entries_d[j] = key_i;
        end
      end
      count_d = count_q + CntW'(1);
      if (state_q == EMPTY) state_d = FILLING;
    end
    if (close_i) state_d = SORTED;
    if (pop_i) begin
      if (at_term) begin
        state_d = EMPTY;
        count_d = '0;
        idx_d   = '0;
      end else begin
        state_d = DRAINING;
        idx_d   = idx_q + CntW'(1);
      end
    end
  end

  // Control state register with synchronous reset; clearing count discards stored keys.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Key storage; validity is tracked by count_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
  end

  assign state_o   = state_q;
  assign count_o   = count_q;
  assign at_term_o = at_term;

endmodule

// File: rtl/run_feeder.sv
// Turns an unsorted key stream into ascending runs of up to RUN_LEN keys, each closed by a 0
// terminator, presented on a first-word-fall-through read port. Two ping-pong banks let one run
// drain while the next fills.
// Optional: define RUN_FEEDER_CHECK_EN for sticky o_err flags (zero key dropped, read while empty).
module run_feeder
  import bonsai_pkg::*;
#(
  parameter int unsigned W       = KEY_W,
  parameter int unsigned RUN_LEN = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_key,
  input  logic         i_key_valid,
  input  logic         i_key_last,
  output logic         o_key_ready,
  output logic [W-1:0] o_fifo_data,
  output logic         o_fifo_empty,
  input  logic         i_fifo_read,
  output logic         o_busy,
  output logic [1:0]   o_err
);

  localparam int unsigned CntW = $clog2(RUN_LEN + 1);

  logic            fill_ptr_q, fill_ptr_d;
  logic            drain_ptr_q, drain_ptr_d;
  bank_state_t     st      [2];
  logic [CntW-1:0] cnt     [2];
  logic            at_term [2];
  logic [W-1:0]    head    [2];
  logic [1:0]      insert_b, close_b, pop_b;
  bank_state_t     fill_st, drain_st;
  logic            accept, key_zero, insert, close, pop, free;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    run_sort_bank #(
      .W       (W),
      .RUN_LEN (RUN_LEN)
    ) u_bank (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .insert_i  (insert_b[b]),
      .key_i     (i_key),
      .close_i   (close_b[b]),
      .pop_i     (pop_b[b]),
      .state_o   (st[b]),
      .count_o   (cnt[b]),
      .at_term_o (at_term[b]),
      .head_o    (head[b])
    );
  end

  // Handshakes, run-close decision and steering of strobes to the fill/drain banks.
  always_comb begin
    fill_st      = st[fill_ptr_q];
    drain_st     = st[drain_ptr_q];
    o_key_ready  = ~i_rst & ((fill_st == EMPTY) || (fill_st == FILLING));
    accept       = i_key_valid & o_key_ready;
    key_zero     = (i_key == W'(TERMINATOR));
    insert       = accept & ~key_zero;
    // A zero key with last only closes a run that already holds keys.
    close        = (insert & (cnt[fill_ptr_q] == CntW'(RUN_LEN - 1)))
                 | (accept & i_key_last & (insert | (cnt[fill_ptr_q] != '0)));
    o_fifo_empty = ~((drain_st == SORTED) || (drain_st == DRAINING));
    pop          = i_fifo_read & ~o_fifo_empty & ~i_rst;
    free         = pop & at_term[drain_ptr_q];
    o_fifo_data  = o_fifo_empty ? '0 : head[drain_ptr_q];
    o_busy       = (st[0] != EMPTY) | (st[1] != EMPTY);
    insert_b     = '0;
    close_b      = '0;
    pop_b        = '0;
    insert_b[fill_ptr_q] = insert;
    close_b[fill_ptr_q]  = close;
    pop_b[drain_ptr_q]   = pop;
    fill_ptr_d   = fill_ptr_q ^ close;
    drain_ptr_d  = drain_ptr_q ^ free;
  end

  // Ping-pong pointers: fill moves on run close, drain moves when the terminator is popped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
    end else begin
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
    end
  end

`ifdef RUN_FEEDER_CHECK_EN
  logic [1:0] err_q;
  logic       zero_drop, rd_empty;

  // Error events seen this cycle.
  always_comb begin
    zero_drop = accept & key_zero;
    rd_empty  = i_fifo_read & o_fifo_empty & ~i_rst;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {rd_empty, zero_drop};
      if (zero_drop) $error("run_feeder: zero key dropped");
      if (rd_empty)  $error("run_feeder: read while empty");
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_run_feeder.sv
// Self-checking bench for run_feeder (RUN_LEN=4): directed scenarios followed by random traffic,
// checked by a queue-based run model and a per-cycle status check.
module tb_run_feeder;

  localparam int unsigned W  = 32;
  localparam int unsigned RL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] key;
  logic         key_v, last, rd;
  logic         o_key_ready, o_fifo_empty, o_busy;
  logic [W-1:0] o_fifo_data;
  logic [1:0]   o_err;

  always #5 clk = ~clk;

  run_feeder #(
    .W       (W),
    .RUN_LEN (RL)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key        (key),
    .i_key_valid  (key_v),
    .i_key_last   (last),
    .o_key_ready  (o_key_ready),
    .o_fifo_data  (o_fifo_data),
    .o_fifo_empty (o_fifo_empty),
    .i_fifo_read  (rd),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] pend  [$];   // keys of the run being collected
  logic [W-1:0] exp_q [$];   // expected read-side words, in order
  int           runs_closed  = 0;
  int           terms_popped = 0;
  bit           err0 = 0, err1 = 0;
  bit           chk_on = 0;
  bit           done = 0;
  int           closed_m;
  logic [1:0]   exp_err;
  logic [W-1:0] want;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
    end
  endtask

  // Scoreboard push: model each accepted key; a closed run is sorted and queued with its 0.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      runs_closed = 0;
      err0 = 0;
    end else if (key_v && o_key_ready) begin
      if (key == 0) err0 = 1;
      else pend.push_back(key);
      if (pend.size() == RL || (last && pend.size() > 0)) begin
        pend.sort();
        foreach (pend[i]) exp_q.push_back(pend[i]);
        exp_q.push_back('0);
        pend.delete();
        runs_closed++;
      end
    end
  end

  // Monitor: each pop the DUT performs is compared with the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      terms_popped = 0;
      err1 = 0;
    end else if (rd) begin
      if (o_fifo_empty) begin
        err1 = 1;
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h required no word", o_fifo_data);
      end else begin
        want = exp_q.pop_front();
        check("pop_data", o_fifo_data, want);
        if (want == 0) terms_popped++;
      end
    end
  end

  // Status check each cycle, after the edge has settled.
  always @(posedge clk) begin
    #3;
    if (chk_on) begin
      closed_m = runs_closed - terms_popped;
`ifdef RUN_FEEDER_CHECK_EN
      exp_err = {err1, err0};
`else
      exp_err = 2'b00;
`endif
      check("key_ready", W'(o_key_ready), W'(!rst && closed_m < 2));
      check("fifo_empty", W'(o_fifo_empty), W'(closed_m == 0));
      check("busy", W'(o_busy), W'(closed_m > 0 || pend.size() > 0));
      check("err", W'(o_err), W'(exp_err));
      check("head", o_fifo_data, (closed_m == 0) ? '0 : exp_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic [W-1:0] k, input bit l);
    bit acc;
    int n;
    acc   = 0;
    n     = 0;
    key_v = 1'b1;
    key   = k;
    last  = l;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = o_key_ready;
      tick();
      n++;
    end
    key_v = 1'b0;
    last  = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL put_timeout: key %0h not accepted, required accept within 300 cycles", k);
    end
  endtask

  task automatic read_n(input int n);
    rd = 1'b1;
    repeat (n) tick();
    rd = 1'b0;
  endtask

  task automatic drain();
    read_n(30);
  endtask

  initial begin
    logic [W-1:0] k;
    int           r;
    bit           want_e;
    rst   = 1'b1;
    key   = '0;
    key_v = 1'b0;
    last  = 1'b0;
    rd    = 1'b0;
    idle(2);
    rst    = 1'b0;
    chk_on = 1;

    // Full run, no reads until it is closed.
    put(32'd7, 0); put(32'd3, 0); put(32'd9, 0); put(32'd5, 0);
    idle(2);
    read_n(5);
    idle(1);

    // Short run closed by last.
    put(32'd4, 0); put(32'd2, 1);
    idle(2);
    read_n(3);
    idle(1);
    check("busy_after_short_run", W'(o_busy), '0);

    // Both banks full: fill stalls until the first run is freed.
    fork
      begin
        for (int i = 0; i < 12; i++) put(32'((i * 7) % 13 + 1), 0);
      end
      begin
        idle(14);
        read_n(15);
      end
    join
    drain();

    // Zero key is dropped and counted.
    put(32'd6, 0); put(32'd0, 0); put(32'd1, 0); put(32'd8, 0); put(32'd2, 0); put(32'd5, 1);
    idle(2);
`ifdef RUN_FEEDER_CHECK_EN
    want_e = 1;
`else
    want_e = 0;
`endif
    check("err0_zero_key", W'(o_err[0]), W'(want_e));
    drain();

    // Unsigned extremes and duplicates.
    put(32'hFFFF_FFFF, 0); put(32'd1, 0); put(32'd1, 0); put(32'hFFFF_FFFF, 0);
    drain();

    // Lone zero with last on an empty bank emits nothing.
    put(32'd0, 1);
    idle(2);
    check("lone_zero_no_run", W'(o_fifo_empty), W'(1));

    // Read while empty, then reset mid-drain.
    read_n(2);
    check("err1_read_empty", W'(o_err[1]), W'(want_e));
    put(32'd12, 0); put(32'd10, 0); put(32'd11, 1);
    idle(2);
    read_n(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("empty_after_reset", W'(o_fifo_empty), W'(1));
    check("busy_after_reset", W'(o_busy), '0);
    idle(2);

    // Random traffic with concurrent random reads.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          r = $urandom_range(0, 99);
          if (r < 8) k = '0;
          else if (r < 16) k = 32'hFFFF_FFFF;
          else k = W'($urandom_range(1, 20));
          put(k, $urandom_range(0, 99) < 15);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        put(32'd3, 1);
        done = 1;
      end
      begin
        while (!done) begin
          rd = ($urandom_range(0, 9) < 6);
          tick();
        end
        rd = 1'b0;
      end
    join
    drain();
    idle(2);
    check("scoreboard_drained", W'(exp_q.size()), '0);
    check("no_open_run", W'(pend.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
